// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared state and buffer-entry types for the instruction-fetch controller
package ifetch_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALTED} fetch_state_t;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_AW = 10;
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_AW-1:0]         pc;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: small synchronous FIFO of fetched {data, pc} entries with flush
module ifetch_fifo import ifetch_pkg::*; #(
  parameter type entry_t = fetch_entry_t,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  entry_t        din,
  output entry_t        dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  // Flush wins over push/pop; pointers wrap naturally since DEPTH is a power of 2
  always_comb begin
    mem_d = mem_q;
    wr_d = wr_q;
    rd_d = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = din;
        wr_d = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end
  // Storage and pointer registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  assign dout  = mem_q[rd_q];
  assign count = count_q;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer with ROM latency absorption, buffering and redirects
module ifetch_ctrl import ifetch_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int RESET_PC   = 0,
  parameter int FIFO_DEPTH = 2,
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  halt,
  output logic [AW-1:0]         imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [AW-1:0]         redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [AW-1:0]         inst_pc,
  output logic                  running
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [AW-1:0]         pc;
  } entry_t;
  fetch_state_t  state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d, inflight_pc_q, inflight_pc_d;
  logic          inflight_q, inflight_d;
  logic          go, issue, push, pop, full, empty;
  logic [CW-1:0] count;
  logic [CW:0]   demand;
  entry_t        din, head;
  // Start issues in the same cycle it arrives so the first word is visible two cycles later
  assign go        = (state_q == RUN) | start;
  assign imem_addr = redirect_valid ? redirect_pc : fetch_pc_q;
  assign pop       = inst_valid & inst_ready;
  assign push      = inflight_q & ~redirect_valid;
  assign demand    = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue     = go & ~halt & (redirect_valid | (demand < (CW+1)'(FIFO_DEPTH)));
  assign din       = '{data: imem_rdata, pc: inflight_pc_q};
  // Next state: halt only matters in RUN and beats a simultaneous start
  always_comb begin
    state_d = (state_q == RUN) ? (halt ? HALTED : RUN) : (start ? RUN : state_q);
  end
  // Fetch PC advances past each issued address; a redirect without issue just retargets it
  always_comb begin
    fetch_pc_d = issue ? ((imem_addr == AW'(MEM_DEPTH-1)) ? '0 : imem_addr + 1'b1)
               : redirect_valid ? redirect_pc : fetch_pc_q;
    inflight_d = issue;
    inflight_pc_d = issue ? imem_addr : inflight_pc_q;
  end
  // State, PC and in-flight tracking registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
      fetch_pc_q <= AW'(RESET_PC);
      inflight_q <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end
  ifetch_fifo #(.entry_t(entry_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .flush  (redirect_valid),
    .din    (din),
    .dout   (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );
  assign inst_valid = ~empty;
  assign inst_data  = empty ? '0 : head.data;
  assign inst_pc    = empty ? '0 : head.pc;
  assign running    = state_q == RUN;
  no_overflow: assert property (@(posedge clock) disable iff (!reset_n) !(push && full && !pop));
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed and randomized checks of ifetch_ctrl against a PC-stream model
module tb_ifetch_ctrl;
  localparam int DW = 32;
  localparam int MD = 128;
  localparam int AW = 7;
  localparam int FD = 2;
  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, halt = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] imem_addr, inst_pc;
  logic [DW-1:0] imem_rdata, inst_data;
  logic          inst_valid, running;
  int            errors = 0, checks = 0, delivered = 0, exp_pc = 0;
  logic          hold_q = 1'b0;
  logic [AW-1:0] hold_pc = '0;

  ifetch_ctrl #(.DATA_WIDTH(DW), .MEM_DEPTH(MD), .RESET_PC(0), .FIFO_DEPTH(FD)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .halt          (halt),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .running       (running)
  );

  always #5 clock = ~clock;
  always @(posedge clock) imem_rdata <= 32'hA000_0000 + 32'(imem_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: consumers see one contiguous PC stream that jumps to the target on a redirect.
  task automatic observe();
    if (hold_q) begin
      chk("hold_valid", inst_valid, 1);
      chk("hold_pc", inst_pc, hold_pc);
    end
    if (inst_valid && inst_ready) begin
      chk("pc", inst_pc, exp_pc);
      chk("data", inst_data, 32'hA000_0000 + exp_pc);
      exp_pc = (exp_pc + 1) % MD;
      delivered++;
    end
    if (redirect_valid) exp_pc = int'(redirect_pc);
    hold_q = inst_valid && !inst_ready && !redirect_valid;
    hold_pc = inst_pc;
  endtask

  task automatic cycle(input logic st, input logic hl, input logic rv, input int rp, input logic rdy);
    @(negedge clock);
    start = st;
    halt = hl;
    redirect_valid = rv;
    redirect_pc = AW'(rp);
    inst_ready = rdy;
    #2 observe();
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, 1'b0, 0, rdy);
  endtask

  initial begin
    automatic int wrap_exp[4] = '{126, 127, 0, 1};
    automatic int snap;
    #2;
    chk("rst_valid", inst_valid, 0);
    chk("rst_data", inst_data, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_running", running, 0);
    chk("rst_addr", imem_addr, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (10) begin
      idle(1'b1);
      chk("boot_valid", inst_valid, 0);
      chk("boot_addr", imem_addr, 0);
    end
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b1);
    chk("start_t0_valid", inst_valid, 0);
    idle(1'b1);
    chk("start_t1_valid", inst_valid, 0);
    chk("start_t1_running", running, 1);
    idle(1'b1);
    chk("start_t2_valid", inst_valid, 1);
    chk("start_t2_pc", inst_pc, 0);
    chk("start_t2_data", inst_data, 32'hA000_0000);
    repeat (20) begin
      idle(1'b1);
      chk("stream_valid", inst_valid, 1);
    end
    chk("stream_count", delivered, 21);
    repeat (5) idle(1'b0);
    chk("bp_head", inst_pc, exp_pc);
    repeat (3) begin
      idle(1'b1);
      chk("bp_release_valid", inst_valid, 1);
    end
    repeat (3) idle(1'b0);
    cycle(1'b0, 1'b0, 1'b1, 100, 1'b0);
    idle(1'b1);
    chk("redir_t1_valid", inst_valid, 0);
    idle(1'b1);
    chk("redir_t2_valid", inst_valid, 1);
    chk("redir_t2_pc", inst_pc, 100);
    cycle(1'b0, 1'b0, 1'b1, 126, 1'b1);
    idle(1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk("wrap_pc", inst_pc, wrap_exp[i]);
    end
    cycle(1'b0, 1'b1, 1'b0, 0, 1'b0);
    repeat (3) idle(1'b0);
    chk("halt_running", running, 0);
    repeat (4) idle(1'b1);
    repeat (4) begin
      idle(1'b1);
      chk("halt_idle_valid", inst_valid, 0);
      chk("halt_addr", imem_addr, exp_pc);
    end
    snap = exp_pc;
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("resume_valid", inst_valid, 1);
    chk("resume_pc", inst_pc, snap);
    for (int i = 0; i < 400; i++) begin
      automatic int r = $urandom_range(0, 99);
      cycle(r < 3, r >= 3 && r < 5, r >= 5 && r < 10, $urandom_range(0, MD-1), $urandom_range(0, 9) < 7);
    end
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b1);
    snap = delivered;
    repeat (6) idle(1'b1);
    chk("live", (delivered - snap) >= 4, 1);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_valid", inst_valid, 0);
    chk("areset_running", running, 0);
    chk("areset_addr", imem_addr, 0);
    exp_pc = 0;
    hold_q = 1'b0;
    start = 1'b0;
    halt = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("restart_valid", inst_valid, 1);
    chk("restart_pc", inst_pc, 0);
    repeat (3) idle(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
